// File: rtl/apb_rr_master_arb.sv
// Round-robin APB master: shares one APB completer port between NREQ requesters.
// Runs one IDLE -> SETUP -> ACCESS transfer at a time, with an optional ACCESS-phase timeout.
module apb_rr_master_arb #(
  parameter int NREQ    = 4,
  parameter int AW      = 3,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                pclk,
  input  logic                preset_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ-1:0]     req_write,
  input  logic [NREQ*AW-1:0]  req_addr,
  input  logic [NREQ*DW-1:0]  req_wdata,
  output logic [NREQ-1:0]     rsp_valid,
  output logic [DW-1:0]       rsp_rdata,
  output logic                rsp_err,
  output logic [AW-1:0]       paddr,
  output logic                pwrite,
  output logic                psel,
  output logic                penable,
  output logic [DW-1:0]       pwdata,
  input  logic [DW-1:0]       prdata,
  input  logic                pready,
  output logic                busy
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST  = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;
  localparam logic [GW-1:0] LAST_INIT = GW'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t          state_reg;
  logic [GW-1:0]   last_grant_reg;
  logic [GW-1:0]   grant_reg;
  logic [CW-1:0]   cnt_reg;

  logic [AW-1:0]   addr_arr  [NREQ];
  logic [DW-1:0]   wdata_arr [NREQ];
  logic [NREQ-1:0] grant_dec;
  logic            found;
  logic [GW-1:0]   pick;
  logic            accept;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign addr_arr[gi]  = req_addr[gi*AW +: AW];
      assign wdata_arr[gi] = req_wdata[gi*DW +: DW];
      assign grant_dec[gi] = (grant_reg == GW'(gi));
      assign req_ready[gi] = accept && (pick == GW'(gi));
    end
  endgenerate

  // Rotating priority: the requester after the last one granted is looked at first.
  always_comb begin
    int idx;
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(last_grant_reg) + i) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        pick  = GW'(idx);
      end
    end
  end

  assign accept = (state_reg == IDLE) && found;
  assign busy   = (state_reg != IDLE);

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_reg      <= IDLE;
      last_grant_reg <= LAST_INIT;
      grant_reg      <= '0;
      cnt_reg        <= '0;
      paddr          <= '0;
      pwrite         <= 1'b0;
      pwdata         <= '0;
      psel           <= 1'b0;
      penable        <= 1'b0;
      rsp_valid      <= '0;
      rsp_err        <= 1'b0;
      rsp_rdata      <= '0;
    end else begin
      // Response outputs are single-cycle pulses.
      rsp_valid <= '0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      case (state_reg)
        IDLE: begin
          if (found) begin
            state_reg      <= SETUP;
            grant_reg      <= pick;
            last_grant_reg <= pick;
            paddr          <= addr_arr[pick];
            pwrite         <= req_write[pick];
            pwdata         <= wdata_arr[pick];
            psel           <= 1'b1;
            penable        <= 1'b0;
          end
        end
        SETUP: begin
          state_reg <= ACCESS;
          penable   <= 1'b1;
          cnt_reg   <= '0;
        end
        ACCESS: begin
          if (pready) begin
            state_reg <= IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= grant_dec;
            rsp_rdata <= pwrite ? '0 : prdata;
          end else if ((TIMEOUT > 0) && (cnt_reg == CNT_LAST)) begin
            state_reg <= IDLE;
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= grant_dec;
            rsp_err   <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          psel      <= 1'b0;
          penable   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_rr_master_arb.sv
// Directed bench for apb_rr_master_arb: write, waited read, fairness, timeout,
// asynchronous reset mid-transfer and a withdrawn request.
module tb_apb_rr_master_arb;
  localparam int NREQ    = 4;
  localparam int AW      = 3;
  localparam int DW      = 32;
  localparam int TIMEOUT = 16;

  logic                pclk = 1'b0;
  logic                preset_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ-1:0]     req_write;
  logic [NREQ*AW-1:0]  req_addr;
  logic [NREQ*DW-1:0]  req_wdata;
  logic [NREQ-1:0]     rsp_valid;
  logic [DW-1:0]       rsp_rdata;
  logic                rsp_err;
  logic [AW-1:0]       paddr;
  logic                pwrite;
  logic                psel;
  logic                penable;
  logic [DW-1:0]       pwdata;
  logic [DW-1:0]       prdata;
  logic                pready;
  logic                busy;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 pclk = ~pclk;

  apb_rr_master_arb #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)
  ) dut (
    .pclk(pclk), .preset_n(preset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .busy(busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_write[i]            = w;
    req_addr[i*AW +: AW]    = a;
    req_wdata[i*DW +: DW]   = d;
  endtask

  initial begin
    logic [NREQ-1:0] exp_oh;
    preset_n  = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    prdata    = '0;
    pready    = 1'b0;

    // Reset values
    #2 preset_n = 1'b0;
    #1;
    check_eq("rst_psel", psel, 0);
    check_eq("rst_penable", penable, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp_err", rsp_err, 0);
    check_eq("rst_rsp_rdata", rsp_rdata, 0);
    check_eq("rst_paddr", paddr, 0);
    check_eq("rst_pwdata", pwdata, 0);
    check_eq("rst_pwrite", pwrite, 0);
    check_eq("rst_req_ready", req_ready, 0);
    tick();
    tick();
    preset_n = 1'b1;
    $display("[TB] reset released");

    // Single write, pready tied high
    set_req(0, 1'b1, 3'd3, 32'h2);
    pready    = 1'b1;
    req_valid = 4'b0001;
    #1;
    check_eq("wr_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    check_eq("wr_setup_psel", psel, 1);
    check_eq("wr_setup_penable", penable, 0);
    check_eq("wr_paddr", paddr, 3);
    check_eq("wr_pwdata", pwdata, 2);
    check_eq("wr_pwrite", pwrite, 1);
    check_eq("wr_busy", busy, 1);
    tick();
    check_eq("wr_access_psel", psel, 1);
    check_eq("wr_access_penable", penable, 1);
    tick();
    check_eq("wr_done_psel", psel, 0);
    check_eq("wr_done_penable", penable, 0);
    check_eq("wr_rsp_valid", rsp_valid, 4'b0001);
    check_eq("wr_rsp_err", rsp_err, 0);
    check_eq("wr_rsp_rdata", rsp_rdata, 0);
    check_eq("wr_idle_busy", busy, 0);
    tick();
    check_eq("wr_rsp_pulse", rsp_valid, 0);
    $display("[TB] write req0 addr=3 wdata=0x2 done");

    // Read with three wait states
    set_req(2, 1'b0, 3'd1, 32'h0);
    pready    = 1'b0;
    prdata    = 32'hdead_beef;
    req_valid = 4'b0100;
    #1;
    check_eq("rd_ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    check_eq("rd_setup_psel", psel, 1);
    check_eq("rd_pwrite", pwrite, 0);
    check_eq("rd_paddr", paddr, 1);
    tick();
    for (int k = 0; k < 4; k++) begin
      check_eq("rd_access_penable", penable, 1);
      check_eq("rd_no_rsp", rsp_valid, 0);
      if (k == 3) begin
        check_eq("rd_paddr_hold", paddr, 1);
        pready = 1'b1;
        prdata = 32'h0000_0009;
      end
      tick();
    end
    check_eq("rd_rsp_valid", rsp_valid, 4'b0100);
    check_eq("rd_rsp_rdata", rsp_rdata, 32'h9);
    check_eq("rd_rsp_err", rsp_err, 0);
    check_eq("rd_done_penable", penable, 0);
    $display("[TB] read req2 addr=1 with 3 wait states done");

    // Fairness from reset with all requesters pending
    preset_n = 1'b0;
    #1;
    tick();
    preset_n = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, AW'(i), DW'(i * 16));
    req_valid = 4'b1111;
    pready    = 1'b1;
    for (int t = 0; t < 6; t++) begin
      #1;
      exp_oh = 4'b0001 << (t % 4);
      check_eq("rr_grant", req_ready, exp_oh);
      if (t > 0) begin
        exp_oh = 4'b0001 << ((t - 1) % 4);
        check_eq("rr_prev_rsp", rsp_valid, exp_oh);
      end
      tick();
      check_eq("rr_paddr", paddr, t % 4);
      if (t == 5) req_valid = '0;
      tick();
      tick();
      $display("[TB] fairness transfer %0d granted requester %0d", t, t % 4);
    end
    check_eq("rr_last_rsp", rsp_valid, 4'b0010);
    check_eq("rr_idle_ready", req_ready, 0);
    check_eq("rr_idle_busy", busy, 0);

    // Timeout with another request pending
    set_req(3, 1'b1, 3'd6, 32'h77);
    set_req(0, 1'b0, 3'd2, 32'h0);
    pready    = 1'b0;
    prdata    = 32'h55;
    req_valid = 4'b1001;
    #1;
    check_eq("to_grant3", req_ready, 4'b1000);
    tick();
    req_valid = 4'b0001;
    check_eq("to_setup_psel", psel, 1);
    check_eq("to_busy_ready", req_ready, 0);
    tick();
    for (int k = 0; k < TIMEOUT; k++) begin
      check_eq("to_access_penable", penable, 1);
      check_eq("to_no_rsp", rsp_valid, 0);
      tick();
    end
    check_eq("to_abort_penable", penable, 0);
    check_eq("to_abort_psel", psel, 0);
    check_eq("to_rsp_valid", rsp_valid, 4'b1000);
    check_eq("to_rsp_err", rsp_err, 1);
    check_eq("to_rsp_rdata", rsp_rdata, 0);
    check_eq("to_next_accept", req_ready, 4'b0001);
    $display("[TB] timeout on req3 reported");
    pready = 1'b1;
    tick();
    req_valid = '0;
    check_eq("to_next_psel", psel, 1);
    check_eq("to_next_paddr", paddr, 2);
    tick();
    tick();
    check_eq("to_next_rsp", rsp_valid, 4'b0001);
    check_eq("to_next_err", rsp_err, 0);
    check_eq("to_next_rdata", rsp_rdata, 32'h55);
    $display("[TB] read req0 after timeout done");

    // Asynchronous reset during ACCESS
    set_req(2, 1'b0, 3'd5, 32'h0);
    pready    = 1'b0;
    req_valid = 4'b0100;
    #1;
    check_eq("ar_grant2", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    tick();
    check_eq("ar_access_penable", penable, 1);
    #2 preset_n = 1'b0;
    #1;
    check_eq("ar_psel", psel, 0);
    check_eq("ar_penable", penable, 0);
    check_eq("ar_busy", busy, 0);
    check_eq("ar_rsp_valid", rsp_valid, 0);
    check_eq("ar_paddr", paddr, 0);
    tick();
    preset_n = 1'b1;
    set_req(0, 1'b1, 3'd4, 32'hA5);
    set_req(3, 1'b1, 3'd7, 32'h0);
    req_valid = 4'b1001;
    pready    = 1'b1;
    #1;
    check_eq("ar_prio0", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    check_eq("ar_pwdata", pwdata, 32'hA5);
    tick();
    tick();
    check_eq("ar_rsp_valid0", rsp_valid, 4'b0001);
    check_eq("ar_rsp_err0", rsp_err, 0);
    $display("[TB] reset mid-transfer, requester 0 regained priority");

    // Withdrawn request while busy
    set_req(0, 1'b1, 3'd3, 32'h11);
    pready    = 1'b0;
    req_valid = 4'b0001;
    #1;
    check_eq("wd_grant0", req_ready, 4'b0001);
    tick();
    req_valid = 4'b0010;
    #1;
    check_eq("wd_busy_ready", req_ready, 0);
    tick();
    tick();
    pready    = 1'b1;
    req_valid = '0;
    tick();
    check_eq("wd_rsp0", rsp_valid, 4'b0001);
    check_eq("wd_no_grant", req_ready, 0);
    tick();
    check_eq("wd_no_psel", psel, 0);
    check_eq("wd_no_busy", busy, 0);
    check_eq("wd_no_rsp", rsp_valid, 0);
    tick();
    check_eq("wd_still_idle", psel, 0);
    $display("[TB] withdrawn req1 produced no transfer");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
